// File: rtl/hcsr04_pkg.sv
// Shared types and constants for the HC-SR04 trigger/echo stages.
// Default cycle counts assume a 50 MHz clock.
package hcsr04_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    ECHO,
    HOLDOFF
  } state_e;

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_NORISE = 2'b01;
  localparam logic [1:0] ERR_OVF    = 2'b10;

  localparam int DEF_TRIG_CYCLES   = 500;
  localparam int DEF_PERIOD_CYCLES = 3000000;
  localparam int DEF_RISE_TIMEOUT  = 50000;
  localparam int DEF_ECHO_MAX      = 1900000;
  localparam int DEF_CNT_W         = 22;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous input, plus a history flop
// that turns the synchronised level into one-cycle rise/fall strobes.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic hist_q, hist_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~hist_q;
  assign fall_o  = ~sync_q & hist_q;

endmodule

// File: rtl/hcsr04_trigger_sequencer.sv
// HC-SR04 trigger sequencer: issues trigger pulses, supervises the echo with
// rise/width timeouts, enforces the repetition period, emits echo strobes.
module hcsr04_trigger_sequencer
  import hcsr04_pkg::*;
#(
  parameter int TRIG_CYCLES   = DEF_TRIG_CYCLES,
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int RISE_TIMEOUT  = DEF_RISE_TIMEOUT,
  parameter int ECHO_MAX      = DEF_ECHO_MAX,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       iCLK_50,
  input  logic       iRST_n,
  input  logic       iEnable,
  input  logic       iSingle,
  input  logic       iEcho,
  output logic       oTrig,
  output logic       oGate,
  output logic       oStart,
  output logic       oDone,
  output logic       oTimeout,
  output logic [1:0] oErr,
  output logic       oBusy
);

  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RISE_LAST   = CNT_W'(RISE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ECHO_LAST   = CNT_W'(ECHO_MAX - 1);
  localparam logic [CNT_W-1:0] PERIOD_MAX  = CNT_W'(PERIOD_CYCLES);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);

  logic echo_s, echo_rise, echo_fall;

  sync_edge_detect u_echo_sync (
    .clk    (iCLK_50),
    .rst_n  (iRST_n),
    .d_in   (iEcho),
    .level_o(echo_s),
    .rise_o (echo_rise),
    .fall_o (echo_fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [1:0]       err_q, err_d;
  logic             trig_q, trig_d, gate_q, gate_d, busy_q, busy_d;
  logic             start_q, start_d, done_q, done_d, timeout_q, timeout_d;
  logic             period_done;

  // Leaving on the cycle the counter reaches its limit keeps trigger-to-trigger
  // spacing at exactly PERIOD_CYCLES in continuous mode.
  assign period_done = (period_q >= PERIOD_LAST);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + CNT_W'(1);
    period_d  = (period_q == PERIOD_MAX) ? period_q : period_q + CNT_W'(1);
    err_d     = err_q;
    start_d   = 1'b0;
    done_d    = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (iEnable || iSingle) state_d = TRIG;
      end
      TRIG: begin
        if (phase_q == TRIG_LAST) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (echo_rise) begin
          state_d = ECHO;
          start_d = 1'b1;
        end else if (phase_q == RISE_LAST) begin
          state_d   = HOLDOFF;
          timeout_d = 1'b1;
          err_d     = ERR_NORISE;
        end
      end
      ECHO: begin
        // A fall on the limit cycle still counts as a valid measurement.
        if (echo_fall) begin
          state_d = HOLDOFF;
          done_d  = 1'b1;
        end else if (phase_q == ECHO_LAST) begin
          state_d   = HOLDOFF;
          timeout_d = 1'b1;
          err_d     = ERR_OVF;
        end
      end
      HOLDOFF: begin
        if (period_done && !echo_s) state_d = iEnable ? TRIG : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) phase_d = '0;
    if (state_d == TRIG && state_q != TRIG) begin
      period_d = '0;
      err_d    = ERR_OK;
    end

    trig_d = (state_d == TRIG);
    gate_d = (state_d == ECHO) && echo_s;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge iCLK_50) begin
    if (!iRST_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      period_q  <= '0;
      err_q     <= ERR_OK;
      trig_q    <= 1'b0;
      gate_q    <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      period_q  <= period_d;
      err_q     <= err_d;
      trig_q    <= trig_d;
      gate_q    <= gate_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign oTrig    = trig_q;
  assign oGate    = gate_q;
  assign oStart   = start_q;
  assign oDone    = done_q;
  assign oTimeout = timeout_q;
  assign oErr     = err_q;
  assign oBusy    = busy_q;

endmodule
